// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the board clock-divider controller.
package clkdiv_pkg;

    localparam int unsigned CntWidth = 26;
    // 1 Hz from 50 MHz: half-period of 25_000_000 cycles.
    localparam logic [CntWidth-1:0] DefDivisor = 26'd24_999_999;

    typedef enum logic [1:0] {
        StStop,
        StRun,
        StPend,
        StDrain
    } ctrl_state_e;

endpackage

// File: rtl/prog_divider.sv
// Programmable divider: counts to div, then wraps, toggles clk_out and pulses tick.
module prog_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W = CntWidth
) (
    input  logic             clock_50M,
    input  logic             reset,
    input  logic [CNT_W-1:0] div,
    input  logic             cnt_en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             clk_out,
    output logic             tick,
    output logic             tc
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    assign tc = cnt_en && (count_q >= div);

    always_comb begin
        count_d   = count_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        if (clr) begin
            count_d   = '0;
            clk_out_d = 1'b0;
        end else if (tc) begin
            count_d   = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
        end else if (cnt_en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_50M) begin
        if (!reset) begin
            count_q   <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign count   = count_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run-time controller: start/stop sequencing and glitch-free divisor updates for prog_divider.
module clkdiv_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W   = CntWidth,
    parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DefDivisor),
    parameter logic [CNT_W-1:0] MIN_DIV = CNT_W'(1)
) (
    input  logic             clock_50M,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             cfg_err
);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] div_active_q, div_active_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             cfg_err_q, cfg_err_d;

    logic cnt_en, clr, tc;
    logic cfg_accept, cfg_take;

    assign cfg_ready  = (state_q == StStop) || (state_q == StRun);
    assign busy       = (state_q == StPend) || (state_q == StDrain);
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_take   = cfg_accept && (cfg_div >= MIN_DIV);

    always_comb begin
        state_d      = state_q;
        div_active_d = div_active_q;
        div_pend_d   = div_pend_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = cfg_accept && !cfg_take;
        cnt_en       = 1'b0;
        clr          = 1'b0;
        unique case (state_q)
            StStop: begin
                clr = 1'b1;
                if (cfg_take) div_active_d = cfg_div;
                if (en) state_d = StRun;
            end
            StRun: begin
                cnt_en = 1'b1;
                if (cfg_take) begin
                    div_pend_d   = cfg_div;
                    pend_valid_d = 1'b1;
                end
                if (!en) state_d = StDrain;
                else if (cfg_take) state_d = StPend;
            end
            StPend: begin
                cnt_en = 1'b1;
                if (tc) begin
                    div_active_d = div_pend_q;
                    pend_valid_d = 1'b0;
                end
                if (!en) state_d = StDrain;
                else if (tc) state_d = StRun;
            end
            StDrain: begin
                // Finish a high half-period so clk_out never emits a runt pulse.
                if (clk_out) begin
                    cnt_en = 1'b1;
                    if (tc) state_d = StStop;
                end else begin
                    clr     = 1'b1;
                    state_d = StStop;
                end
                if ((state_d == StStop) && pend_valid_q) begin
                    div_active_d = div_pend_q;
                    pend_valid_d = 1'b0;
                end
            end
            default: state_d = StStop;
        endcase
    end

    always_ff @(posedge clock_50M) begin
        if (!reset) begin
            state_q      <= StStop;
            div_active_q <= DEF_DIV;
            div_pend_q   <= DEF_DIV;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_active_q <= div_active_d;
            div_pend_q   <= div_pend_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    prog_divider #(
        .CNT_W (CNT_W)
    ) u_prog_divider (
        .clock_50M (clock_50M),
        .reset     (reset),
        .div       (div_active_q),
        .cnt_en    (cnt_en),
        .clr       (clr),
        .count     (count),
        .clk_out   (clk_out),
        .tick      (tick),
        .tc        (tc)
    );

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl with DEF_DIV=3; tick intervals are scoreboarded.
module tb_clkdiv_ctrl;

    localparam int unsigned W = 26;

    logic         clock_50M;
    logic         reset;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] count;
    logic         busy;
    logic         cfg_err;

    clkdiv_ctrl #(
        .CNT_W   (W),
        .DEF_DIV (26'd3),
        .MIN_DIV (26'd1)
    ) dut (
        .clock_50M (clock_50M),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .count     (count),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial begin
        clock_50M = 1'b0;
        forever #5 clock_50M = ~clock_50M;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [W-1:0] div;
        logic         exp_err;
        int unsigned  exp_half;
    } vec_t;

    vec_t        vecs[5];
    int unsigned sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_tick = 0;
    bit          have_last = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge; every tick seen is matched against the expected half-period queue.
    task automatic step();
        int unsigned exp;
        @(posedge clock_50M);
        #1;
        cyc++;
        if (reset === 1'b0) begin
            have_last = 0;
        end else if (tick === 1'b1) begin
            if (have_last) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tick_unexpected: tick at cycle %0d, expected none", cyc);
                end else begin
                    exp = sb.pop_front();
                    chk("half_period", 32'(cyc - last_tick), exp);
                end
            end
            have_last = 1;
            last_tick = cyc;
        end
    endtask

    task automatic new_run();
        have_last = 0;
    endtask

    task automatic cfg(input logic [W-1:0] d);
        cfg_valid = 1'b1;
        cfg_div   = d;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_stop();
        en = 1'b0;
        step();
        for (int i = 0; i < 40 && busy === 1'b1; i++) step();
        chk("stop_busy", 32'(busy), 0);
        chk("stop_count", 32'(count), 0);
        chk("stop_clk_out", 32'(clk_out), 0);
    endtask

    task automatic push_n(input int n, input int unsigned h);
        for (int i = 0; i < n; i++) sb.push_back(h);
    endtask

    initial begin
        vecs[0] = '{div: 26'd3, exp_err: 1'b0, exp_half: 4};
        vecs[1] = '{div: 26'd1, exp_err: 1'b0, exp_half: 2};
        vecs[2] = '{div: 26'd0, exp_err: 1'b1, exp_half: 2};
        vecs[3] = '{div: 26'd5, exp_err: 1'b0, exp_half: 6};
        vecs[4] = '{div: 26'd3, exp_err: 1'b0, exp_half: 4};

        reset = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step();
        step();
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
        reset = 1'b1;
        step();
        chk("idle_count", 32'(count), 0);

        // Configure in STOP, then run and measure the period.
        for (int v = 0; v < 5; v++) begin
            chk("cfg_ready_stop", 32'(cfg_ready), 1);
            cfg(vecs[v].div);
            chk("cfg_err", 32'(cfg_err), 32'(vecs[v].exp_err));
            step();
            chk("cfg_err_clear", 32'(cfg_err), 0);
            new_run();
            push_n(3, vecs[v].exp_half);
            en = 1'b1;
            step();
            chk("run_count0", 32'(count), 0);
            chk("run_busy", 32'(busy), 0);
            for (int i = 1; i < int'(vecs[v].exp_half); i++) begin
                step();
                chk("count_seq", 32'(count), 32'(i));
            end
            step();
            chk("first_tick", 32'(tick), 1);
            chk("first_clk_out", 32'(clk_out), 1);
            chk("first_count", 32'(count), 0);
            repeat (3 * vecs[v].exp_half) step();
            chk("last_tick", 32'(tick), 1);
            chk("last_clk_out", 32'(clk_out), 0);
            wait_stop();
            chk("sb_empty", 32'(sb.size()), 0);
        end

        // Reconfigure mid half-period.
        new_run();
        en = 1'b1;
        step();
        repeat (4) step();
        chk("a_first_tick", 32'(tick), 1);
        step();
        chk("a_count1", 32'(count), 1);
        push_n(1, 4);
        push_n(2, 2);
        cfg(26'd1);
        chk("a_ready_low", 32'(cfg_ready), 0);
        chk("a_busy", 32'(busy), 1);
        chk("a_count2", 32'(count), 2);
        step();
        chk("a_busy2", 32'(busy), 1);
        step();
        chk("a_apply_tick", 32'(tick), 1);
        chk("a_busy_done", 32'(busy), 0);
        chk("a_ready_back", 32'(cfg_ready), 1);
        repeat (4) step();
        chk("a_fast_tick", 32'(tick), 1);
        wait_stop();
        chk("a_sb_empty", 32'(sb.size()), 0);
        cfg(26'd3);

        // Illegal divisor while running, then a clean stop from clk_out=1.
        new_run();
        en = 1'b1;
        step();
        repeat (4) step();
        push_n(3, 4);
        cfg(26'd0);
        chk("b_cfg_err", 32'(cfg_err), 1);
        chk("b_ready", 32'(cfg_ready), 1);
        chk("b_busy", 32'(busy), 0);
        step();
        chk("b_cfg_err_pulse", 32'(cfg_err), 0);
        step();
        step();
        chk("b_tick_same_period", 32'(tick), 1);
        repeat (4) step();
        chk("b_clk_out_high", 32'(clk_out), 1);
        step();
        chk("b_count1", 32'(count), 1);
        en = 1'b0;
        step();
        chk("b_drain_busy", 32'(busy), 1);
        chk("b_drain_count2", 32'(count), 2);
        chk("b_drain_ready", 32'(cfg_ready), 0);
        step();
        chk("b_drain_clk_high", 32'(clk_out), 1);
        step();
        chk("b_stop_fall", 32'(clk_out), 0);
        chk("b_stop_tick", 32'(tick), 1);
        chk("b_stop_busy", 32'(busy), 0);
        repeat (8) step();
        chk("b_held_count", 32'(count), 0);
        chk("b_sb_empty", 32'(sb.size()), 0);

        // Config accepted on the TC cycle.
        new_run();
        en = 1'b1;
        step();
        repeat (4) step();
        push_n(2, 4);
        push_n(3, 2);
        repeat (3) step();
        chk("c_at_tc", 32'(count), 3);
        cfg(26'd1);
        chk("c_old_div_tick", 32'(tick), 1);
        chk("c_pend_ready", 32'(cfg_ready), 0);
        repeat (4) step();
        chk("c_apply_tick", 32'(tick), 1);
        chk("c_busy_done", 32'(busy), 0);
        repeat (4) step();
        chk("c_fast_tick", 32'(tick), 1);
        en = 1'b0;
        step();
        chk("c_drain_busy", 32'(busy), 1);
        step();
        chk("c_drain_tick", 32'(tick), 1);
        chk("c_stop_clk_out", 32'(clk_out), 0);
        chk("c_sb_empty", 32'(sb.size()), 0);
        cfg(26'd3);

        // en drop together with a config accept: divisor lands on STOP entry.
        new_run();
        en = 1'b1;
        step();
        en = 1'b0;
        chk("d_ready", 32'(cfg_ready), 1);
        cfg(26'd1);
        chk("d_drain_busy", 32'(busy), 1);
        step();
        chk("d_stop_busy", 32'(busy), 0);
        chk("d_stop_count", 32'(count), 0);
        new_run();
        en = 1'b1;
        step();
        step();
        chk("d_count1", 32'(count), 1);
        step();
        chk("d_new_div_tick", 32'(tick), 1);
        push_n(3, 2);
        repeat (4) step();
        chk("d_clk_out", 32'(clk_out), 1);
        en = 1'b0;
        step();
        step();
        chk("d_drain_tick", 32'(tick), 1);
        chk("d_sb_empty", 32'(sb.size()), 0);
        cfg(26'd3);

        // Reset while a divisor is pending.
        new_run();
        en = 1'b1;
        step();
        repeat (5) step();
        cfg(26'd1);
        chk("e_in_pend", 32'(busy), 1);
        reset = 1'b0;
        step();
        chk("e_rst_clk_out", 32'(clk_out), 0);
        chk("e_rst_tick", 32'(tick), 0);
        chk("e_rst_count", 32'(count), 0);
        chk("e_rst_busy", 32'(busy), 0);
        chk("e_rst_ready", 32'(cfg_ready), 1);
        reset = 1'b1;
        new_run();
        step();
        repeat (4) step();
        chk("e_first_tick", 32'(tick), 1);
        push_n(3, 4);
        repeat (8) step();
        chk("e_period8_tick", 32'(tick), 1);
        wait_stop();
        chk("e_sb_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Run-time controller for the board clock-divider datapath. It owns a programmable divider on `clock_50M`, starts and stops it cleanly, and accepts new divisor values over a valid/ready handshake. New divisors are applied only at a terminal-count boundary, so `clk_out` never produces a runt half-period. It sits between the control logic (switch/UART/register front end) and every consumer of the slow `clk_out`/`tick` timebase.

## Interface

Parameters:
- `CNT_W`, 26, counter and divisor width.
- `DEF_DIV`, 26'd24_999_999, divisor loaded at reset; gives 1 Hz `clk_out` from 50 MHz.
- `MIN_DIV`, 1, smallest legal divisor; smaller requests are rejected.

Ports:
- `clock_50M`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-low.
- `en`  in  1  run request; level-sensitive.
- `cfg_valid`  in  1  divisor update request.
- `cfg_div`  in  CNT_W  requested divisor; half-period is `cfg_div+1` cycles.
- `cfg_ready`  out  1  update can be accepted; combinational from state.
- `clk_out`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle pulse, registered, high in the cycle `clk_out` changes.
- `count`  out  CNT_W  current divider count, registered.
- `busy`  out  1  high in PEND or DRAIN.
- `cfg_err`  out  1  one-cycle pulse when a rejected divisor is accepted.

## Operation

- Reset values: `clk_out`=0, `tick`=0, `count`=0, `cfg_err`=0, `busy`=0, state=STOP, `div_active`=DEF_DIV, `div_pend`=DEF_DIV.
- Terminal count (TC) is `count >= div_active` while counting. At TC, `count` is set to 0, `clk_out` toggles, and `tick` is 1. Otherwise `count` increments by 1, modulo 2^CNT_W, with no saturation.
- STOP state:
  - `count` is held at 0 and `clk_out` at 0.
  - `cfg_ready`=1. An accepted legal `cfg_div` writes `div_active` directly.
  - `en`=1 moves to RUN.
- RUN state:
  - The divider counts and `cfg_ready`=1.
  - An accepted legal `cfg_div` is stored in `div_pend` and the state moves to PEND.
  - `en`=0 moves to DRAIN.
- PEND state:
  - The divider counts and `cfg_ready`=0.
  - At the next TC, `div_active` takes `div_pend` and the state returns to RUN.
  - `en`=0 moves to DRAIN, and the pending value is kept.
- DRAIN state:
  - If `clk_out`=0, move to STOP at once, clearing `count`.
  - If `clk_out`=1, keep counting until TC, which drives `clk_out` to 0, then move to STOP.
  - `cfg_ready`=0.
  - On entering STOP, any pending divisor is applied to `div_active`.
  - `en` returning to 1 during DRAIN has no effect until STOP is reached.
- Illegal request (`cfg_div < MIN_DIV`): the handshake still completes, `cfg_err` pulses the next cycle, and the state and divisors are unchanged.
- Config accepted in the same cycle as TC in RUN: that TC uses the old divisor, and the new value is applied at the following TC.
- `en`=0 and a config accept in the same RUN cycle: the divisor goes to `div_pend`, the state moves to DRAIN, and the divisor is applied on entering STOP.
- Reset asserted mid-operation: all state returns to reset values on the next edge, and any pending divisor is discarded.

## Timing

- `clk_out` period = 2·(`div_active`+1) cycles of `clock_50M`.
- Start latency: `en` rises in STOP; the state is RUN after 1 edge; the first TC occurs `div_active`+1 edges later.
- Config apply latency in RUN is at most `div_active`+1 cycles after accept, taking effect at the next TC boundary.
- Stop latency is at most 2·(`div_active`+1) cycles.
- `tick` is coincident with the registered `clk_out` edge, with zero-cycle skew between them.

## Structure

- Package `clkdiv_pkg` holds:
  - the state enum {STOP, RUN, PEND, DRAIN};
  - the `CNT_W` default;
  - the `DEF_DIV` constant.
- Sub-module `prog_divider` provides:
  - inputs `div`, `cnt_en`, `clr`;
  - the count register and `clk_out` toggle;
  - the `tc` pulse output.
- The FSM, `div_active`/`div_pend` registers and handshake logic stay in `clkdiv_ctrl`.

## Test plan

All scenarios use `DEF_DIV`=3 in simulation.

- **Reset then run:** release reset, raise `en`. Required: first `tick` 4 cycles after RUN, `clk_out` period 8 cycles, `count` sequence 0,1,2,3,0.
- **Reconfigure while running:** send `cfg_div`=1 mid half-period. Required: `cfg_ready` drops; current half-period still lasts 4 cycles; subsequent half-periods last 2 cycles; `busy` is high only until that TC.
- **Illegal divisor:** with `MIN_DIV`=1, send `cfg_div`=0. Required: `cfg_err` pulses one cycle and the period is unchanged at 8.
- **Clean stop:** drop `en` while `clk_out`=1, `count`=1. Required: 2 more cycles, then `clk_out` falls, state is STOP, `count` is held at 0, and no further `tick`.
- **Collisions:** accept a config exactly on TC, and separately drop `en` together with a config accept. Required: the new divisor is applied at the following TC, or on STOP entry respectively.
- **Mid-operation reset:** assert `reset` in PEND. Required: next cycle all outputs are at reset values, and after restart the period is 8, not the pending value.
